// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the data bus for loads/stores and owns the MEM/WB registers.
// Optional build macro MISALIGN_TRAP_EN turns misaligned half/word accesses into a trap.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rd_from_exmem,
    input  logic        write_reg_from_exmem,
    input  logic        read_mem_from_exmem,
    input  logic        write_mem_from_exmem,
    input  logic [31:0] result_from_exmem,
    input  logic [31:0] data_to_mem_from_exmem,
    input  logic [1:0]  size_from_exmem,
    input  logic        unsigned_from_exmem,
    input  logic        wb_stall,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata,
    output logic        mem_stall,
    output logic [4:0]  rd_to_wb,
    output logic        write_reg_to_wb,
    output logic [31:0] result_to_wb,
    output logic        misalign_exc_to_wb,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        WAIT_R   = 2'd2,
        HOLD     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] hold_buf_q, hold_buf_d;
    logic [4:0]  rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] res_q, res_d;

    logic        is_mem, misaligned, mem_op, req;
    logic [1:0]  off;
    logic [31:0] shifted, load_data;

    assign is_mem = read_mem_from_exmem | write_mem_from_exmem;

`ifdef MISALIGN_TRAP_EN
    assign misaligned = is_mem &&
                        ((size_from_exmem == 2'b01 && result_from_exmem[0]) ||
                         (size_from_exmem[1] && result_from_exmem[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign mem_op = is_mem & ~misaligned;

    // Byte offset inside the word; half/word accesses drop the low address bits.
    always_comb begin
        case (size_from_exmem)
            2'b00:   off = result_from_exmem[1:0];
            2'b01:   off = {result_from_exmem[1], 1'b0};
            default: off = 2'b00;
        endcase
    end

    always_comb begin
        case (size_from_exmem)
            2'b00: begin
                dbus_be    = 4'b0001 << result_from_exmem[1:0];
                dbus_wdata = {4{data_to_mem_from_exmem[7:0]}};
            end
            2'b01: begin
                dbus_be    = result_from_exmem[1] ? 4'b1100 : 4'b0011;
                dbus_wdata = {2{data_to_mem_from_exmem[15:0]}};
            end
            default: begin
                dbus_be    = 4'b1111;
                dbus_wdata = data_to_mem_from_exmem;
            end
        endcase
    end

    assign shifted = dbus_rdata >> {off, 3'b000};

    always_comb begin
        case (size_from_exmem)
            2'b00:   load_data = {{24{~unsigned_from_exmem & shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{16{~unsigned_from_exmem & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // Bus handshake: an access is accepted in the cycle where dbus_req && dbus_gnt;
    // req stays high with address/data stable until then. Read data is taken on the
    // first dbus_rvalid in WAIT_R; rvalid in any other state is dropped.
    always_comb begin
        state_d    = state_q;
        hold_buf_d = hold_buf_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        res_d      = res_q;
        req        = 1'b0;
        mem_stall  = wb_stall;
        if (!wb_stall) begin
            rd_d  = 5'd0;
            wr_d  = 1'b0;
            res_d = 32'd0;
        end
        case (state_q)
            IDLE: begin
                if (!wb_stall) begin
                    if (!mem_op) begin
                        rd_d  = rd_from_exmem;
                        wr_d  = write_reg_from_exmem & ~misaligned;
                        res_d = result_from_exmem;
                    end else begin
                        req = 1'b1;
                        if (!dbus_gnt) begin
                            state_d   = WAIT_GNT;
                            mem_stall = 1'b1;
                        end else if (read_mem_from_exmem) begin
                            state_d   = WAIT_R;
                            mem_stall = 1'b1;
                        end
                    end
                end
            end
            WAIT_GNT: begin
                mem_stall = 1'b1;
                if (!wb_stall) begin
                    req = 1'b1;
                    if (dbus_gnt) begin
                        if (read_mem_from_exmem) begin
                            state_d = WAIT_R;
                        end else begin
                            state_d   = IDLE;
                            mem_stall = 1'b0;
                        end
                    end
                end
            end
            WAIT_R: begin
                mem_stall = 1'b1;
                if (dbus_rvalid) begin
                    if (wb_stall) begin
                        hold_buf_d = load_data;
                        state_d    = HOLD;
                    end else begin
                        rd_d      = rd_from_exmem;
                        wr_d      = write_reg_from_exmem;
                        res_d     = load_data;
                        state_d   = IDLE;
                        mem_stall = 1'b0;
                    end
                end
            end
            HOLD: begin
                mem_stall = 1'b1;
                if (!wb_stall) begin
                    rd_d      = rd_from_exmem;
                    wr_d      = write_reg_from_exmem;
                    res_d     = hold_buf_q;
                    state_d   = IDLE;
                    mem_stall = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_buf_q <= 32'd0;
            rd_q       <= 5'd0;
            wr_q       <= 1'b0;
            res_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            hold_buf_q <= hold_buf_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            res_q      <= res_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic mis_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_q <= 1'b0;
        end else if (!wb_stall) begin
            mis_q <= (state_q == IDLE) && misaligned;
        end
    end
    assign misalign_exc_to_wb = mis_q;
`else
    assign misalign_exc_to_wb = 1'b0;
`endif

    // Reset must pull the request down at once, even while a load sits in EX/MEM.
    assign dbus_req        = req & ~rst;
    assign dbus_we         = dbus_req & write_mem_from_exmem;
    assign dbus_addr       = {result_from_exmem[31:2], 2'b00};
    assign rd_to_wb        = rd_q;
    assign write_reg_to_wb = wr_q;
    assign result_to_wb    = res_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios followed by randomized loads/stores/ALU ops,
// each checked against an arithmetic model of the stage's bus and writeback behaviour.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_from_exmem;
    logic        write_reg_from_exmem;
    logic        read_mem_from_exmem;
    logic        write_mem_from_exmem;
    logic [31:0] result_from_exmem;
    logic [31:0] data_to_mem_from_exmem;
    logic [1:0]  size_from_exmem;
    logic        unsigned_from_exmem;
    logic        wb_stall;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_be;
    logic        dbus_gnt;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;
    logic        mem_stall;
    logic [4:0]  rd_to_wb;
    logic        write_reg_to_wb;
    logic [31:0] result_to_wb;
    logic        misalign_exc_to_wb;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    mem_stage dut (
        .clk                    (clk),
        .rst                    (rst),
        .rd_from_exmem          (rd_from_exmem),
        .write_reg_from_exmem   (write_reg_from_exmem),
        .read_mem_from_exmem    (read_mem_from_exmem),
        .write_mem_from_exmem   (write_mem_from_exmem),
        .result_from_exmem      (result_from_exmem),
        .data_to_mem_from_exmem (data_to_mem_from_exmem),
        .size_from_exmem        (size_from_exmem),
        .unsigned_from_exmem    (unsigned_from_exmem),
        .wb_stall               (wb_stall),
        .dbus_req               (dbus_req),
        .dbus_we                (dbus_we),
        .dbus_addr              (dbus_addr),
        .dbus_wdata             (dbus_wdata),
        .dbus_be                (dbus_be),
        .dbus_gnt               (dbus_gnt),
        .dbus_rvalid            (dbus_rvalid),
        .dbus_rdata             (dbus_rdata),
        .mem_stall              (mem_stall),
        .rd_to_wb               (rd_to_wb),
        .write_reg_to_wb        (write_reg_to_wb),
        .result_to_wb           (result_to_wb),
        .misalign_exc_to_wb     (misalign_exc_to_wb),
        .state_dbg              (state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Scoreboard checks
    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference model
    function automatic int model_off(input logic [31:0] addr, input logic [1:0] size);
        if (size == 2'd0) return int'(addr % 4);
        if (size == 2'd1) return ((addr % 4) >= 2) ? 2 : 0;
        return 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size,
                                               input logic uns, input logic [31:0] word);
        logic [31:0] v;
        v = word >> (8 * model_off(addr, size));
        if (size == 2'd0) begin
            v = v & 32'hFF;
            if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
        end else if (size == 2'd1) begin
            v = v & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic [31:0] addr, input logic [1:0] size);
        if (size == 2'd0) return 4'(1 << (addr % 4));
        if (size == 2'd1) return ((addr % 4) >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] data, input logic [1:0] size);
        if (size == 2'd0) return (data & 32'hFF) * 32'h01010101;
        if (size == 2'd1) return (data & 32'hFFFF) * 32'h00010001;
        return data;
    endfunction

`ifdef MISALIGN_TRAP_EN
    function automatic logic model_misaligned(input logic [31:0] addr, input logic [1:0] size);
        if (size == 2'd1) return (addr % 2) != 0;
        if (size >= 2'd2) return (addr % 4) != 0;
        return 1'b0;
    endfunction
`endif

    // Driver: one EX/MEM instruction from issue to writeback.
    // kind: 0 ALU op, 1 load, 2 store.
    task automatic run_txn(input string tag, input int kind, input logic [4:0] a_rd,
                           input logic a_wr, input logic [31:0] a_res, input logic [31:0] a_data,
                           input logic [1:0] a_size, input logic a_uns, input int gnt_dly,
                           input int rv_dly, input int hold, input logic [31:0] rword);
        int stalls = 0;
        rd_from_exmem          = a_rd;
        write_reg_from_exmem   = a_wr;
        result_from_exmem      = a_res;
        data_to_mem_from_exmem = a_data;
        size_from_exmem        = a_size;
        unsigned_from_exmem    = a_uns;
        read_mem_from_exmem    = (kind == 1);
        write_mem_from_exmem   = (kind == 2);
        dbus_gnt               = 1'b0;
        dbus_rvalid            = 1'b0;
        wb_stall               = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if (kind != 0 && model_misaligned(a_res, a_size)) begin
            settle();
            check1({tag, ".trap_stall"}, mem_stall, 1'b0);
            check1({tag, ".trap_req"}, dbus_req, 1'b0);
            tick();
            check1({tag, ".trap_exc"}, misalign_exc_to_wb, 1'b1);
            check1({tag, ".trap_wr"}, write_reg_to_wb, 1'b0);
            return;
        end
`endif
        if (kind == 0) begin
            exp_q.push_back(a_res);
            settle();
            check1({tag, ".stall"}, mem_stall, 1'b0);
            check1({tag, ".req"}, dbus_req, 1'b0);
            tick();
            check32({tag, ".rd"}, 32'(rd_to_wb), 32'(a_rd));
            check1({tag, ".wr"}, write_reg_to_wb, a_wr);
            check32({tag, ".result"}, result_to_wb, exp_q.pop_front());
            check1({tag, ".exc"}, misalign_exc_to_wb, 1'b0);
            return;
        end
        if (kind == 1) exp_q.push_back(model_load(a_res, a_size, a_uns, rword));
        for (int c = 0; c <= gnt_dly; c++) begin
            dbus_gnt = (c == gnt_dly);
            settle();
            check1({tag, ".req"}, dbus_req, 1'b1);
            check1({tag, ".we"}, dbus_we, kind == 2);
            check32({tag, ".addr"}, dbus_addr, a_res & ~32'h3);
            if (kind == 2) begin
                check32({tag, ".be"}, 32'(dbus_be), 32'(model_be(a_res, a_size)));
                check32({tag, ".wdata"}, dbus_wdata, model_wdata(a_data, a_size));
            end
            check1({tag, ".gnt_stall"}, mem_stall, (kind == 1) || (c < gnt_dly));
            if (mem_stall === 1'b1) stalls++;
            tick();
            dbus_gnt = 1'b0;
            check1({tag, ".bubble"}, write_reg_to_wb, 1'b0);
        end
        if (kind == 2) begin
            check32({tag, ".stall_cnt"}, 32'(stalls), 32'(gnt_dly));
            return;
        end
        for (int c = 0; c <= rv_dly; c++) begin
            dbus_rvalid = (c == rv_dly);
            dbus_rdata  = (c == rv_dly) ? rword : $urandom();
            wb_stall    = (c == rv_dly) && (hold > 0);
            settle();
            check1({tag, ".r_req"}, dbus_req, 1'b0);
            check1({tag, ".r_stall"}, mem_stall, !((c == rv_dly) && (hold == 0)));
            if (mem_stall === 1'b1) stalls++;
            tick();
            dbus_rvalid = 1'b0;
            dbus_rdata  = $urandom();
            if (c < rv_dly) check1({tag, ".r_bubble"}, write_reg_to_wb, 1'b0);
        end
        if (hold > 0) begin
            check1({tag, ".held_wr"}, write_reg_to_wb, 1'b0);
            for (int h = 1; h < hold; h++) begin
                wb_stall = 1'b1;
                settle();
                check1({tag, ".hold_stall"}, mem_stall, 1'b1);
                if (mem_stall === 1'b1) stalls++;
                tick();
                check1({tag, ".hold_wr"}, write_reg_to_wb, 1'b0);
            end
            wb_stall = 1'b0;
            settle();
            check1({tag, ".release_stall"}, mem_stall, 1'b0);
            tick();
        end
        check32({tag, ".rd"}, 32'(rd_to_wb), 32'(a_rd));
        check1({tag, ".wr"}, write_reg_to_wb, a_wr);
        check32({tag, ".result"}, result_to_wb, exp_q.pop_front());
        check1({tag, ".exc"}, misalign_exc_to_wb, 1'b0);
        check32({tag, ".stall_cnt"}, 32'(stalls), 32'(gnt_dly + 1 + rv_dly + hold));
    endtask

    initial begin
        // Reset with a load sitting on the inputs: no request may escape.
        rst                    = 1'b1;
        rd_from_exmem          = 5'd1;
        write_reg_from_exmem   = 1'b1;
        read_mem_from_exmem    = 1'b1;
        write_mem_from_exmem   = 1'b0;
        result_from_exmem      = 32'h10;
        data_to_mem_from_exmem = 32'd0;
        size_from_exmem        = 2'd2;
        unsigned_from_exmem    = 1'b0;
        wb_stall               = 1'b0;
        dbus_gnt               = 1'b0;
        dbus_rvalid            = 1'b0;
        dbus_rdata             = 32'd0;
        tick();
        check1("rst.req", dbus_req, 1'b0);
        check32("rst.rd", 32'(rd_to_wb), 32'd0);
        check1("rst.wr", write_reg_to_wb, 1'b0);
        check32("rst.result", result_to_wb, 32'd0);
        check1("rst.exc", misalign_exc_to_wb, 1'b0);
        read_mem_from_exmem = 1'b0;
        rst = 1'b0;

        // ALU op passes straight through
        run_txn("alu", 0, 5'd5, 1'b1, 32'h1234, 32'd0, 2'd2, 1'b0, 0, 0, 0, 32'd0);
        check32("alu.const", result_to_wb, 32'h1234);

        // Byte store, granted immediately
        run_txn("sb", 2, 5'd3, 1'b0, 32'h103, 32'hAB, 2'd0, 1'b0, 0, 0, 0, 32'd0);

        // Signed half load, grant after two waiting cycles
        run_txn("lh", 1, 5'd9, 1'b1, 32'h202, 32'd0, 2'd1, 1'b0, 2, 0, 0, 32'h8001_0000);
        check32("lh.const", result_to_wb, 32'hFFFF8001);

        // wb_stall in IDLE: no request, WB holds the previous ALU result
        run_txn("alu55", 0, 5'd4, 1'b1, 32'h55, 32'd0, 2'd2, 1'b0, 0, 0, 0, 32'd0);
        read_mem_from_exmem = 1'b1;
        result_from_exmem   = 32'h40;
        wb_stall            = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            check1("wbs.req", dbus_req, 1'b0);
            check1("wbs.stall", mem_stall, 1'b1);
            tick();
            check32("wbs.result", result_to_wb, 32'h55);
            check1("wbs.wr", write_reg_to_wb, 1'b1);
            check32("wbs.rd", 32'(rd_to_wb), 32'd4);
        end
        run_txn("lw40", 1, 5'd8, 1'b1, 32'h40, 32'd0, 2'd2, 1'b0, 0, 1, 0, 32'h1357_9BDF);

        // rvalid under wb_stall for two cycles goes through the hold buffer
        run_txn("lw_hold", 1, 5'd12, 1'b1, 32'h84, 32'd0, 2'd2, 1'b0, 1, 0, 2, 32'hCAFE_F00D);

        // Asynchronous clear of the WB registers
        run_txn("alu_pre", 0, 5'd7, 1'b1, 32'hDEAD_0000, 32'd0, 2'd2, 1'b0, 0, 0, 0, 32'd0);
        rst = 1'b1;
        settle();
        check32("arst.rd", 32'(rd_to_wb), 32'd0);
        check1("arst.wr", write_reg_to_wb, 1'b0);
        check32("arst.result", result_to_wb, 32'd0);
        tick();
        rst = 1'b0;

        // Reset while waiting for read data; the late rvalid must be ignored
        rd_from_exmem        = 5'd6;
        write_reg_from_exmem = 1'b1;
        read_mem_from_exmem  = 1'b1;
        write_mem_from_exmem = 1'b0;
        result_from_exmem    = 32'h48;
        size_from_exmem      = 2'd2;
        dbus_gnt             = 1'b1;
        settle();
        check1("wr_rst.req", dbus_req, 1'b1);
        tick();
        dbus_gnt = 1'b0;
        rst = 1'b1;
        settle();
        check1("wr_rst.req_drop", dbus_req, 1'b0);
        check1("wr_rst.wr", write_reg_to_wb, 1'b0);
        tick();
        rst = 1'b0;
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'h1111_1111;
        settle();
        check1("late_rv.stall", mem_stall, 1'b1);
        tick();
        dbus_rvalid = 1'b0;
        check1("late_rv.wr", write_reg_to_wb, 1'b0);
        check32("late_rv.result", result_to_wb, 32'd0);
        run_txn("lw_after_rst", 1, 5'd6, 1'b1, 32'h48, 32'd0, 2'd2, 1'b0, 0, 0, 0, 32'h2222_2222);

        // Word load at an unaligned address (traps only when the trap build is enabled)
        run_txn("lw_301", 1, 5'd3, 1'b1, 32'h301, 32'd0, 2'd2, 1'b0, 0, 0, 0, 32'h89AB_CDEF);

        // Randomized mix
        for (int i = 0; i < 60; i++) begin
            run_txn($sformatf("rnd%0d", i), $urandom_range(0, 2), 5'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)), $urandom(), $urandom(), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom_range(0, 2), $urandom());
        end
        read_mem_from_exmem  = 1'b0;
        write_mem_from_exmem = 1'b0;
        tick();

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
